// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq
// Purpose  : Program-counter sequencer with relative branches through an
//            8-entry offset table and a one-cycle bubble after a taken branch.
//            Optional BRANCH_COUNT_EN macro adds a saturating taken-branch count.
// Revision : 1.0 - initial release
// ============================================================================
module branch_seq #(
    parameter int D = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         branch_en_i,
    input  logic         cond_i,
    input  logic [2:0]   how_high_i,
    input  logic         halt_req_i,
    input  logic         tbl_we_i,
    input  logic [2:0]   tbl_addr_i,
    input  logic [D-1:0] tbl_data_i,
`ifdef BRANCH_COUNT_EN
    output logic [15:0]  taken_cnt_o,
`endif
    output logic [D-1:0] prog_ctr_o,
    output logic         fetch_valid_o,
    output logic         flush_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [D-1:0]   tbl_q [8];
    logic           w_taken;
    logic           w_enter_flush;

    // Reset values of the offset table, sign-extended or truncated to D bits.
    function automatic logic [D-1:0] tbl_default(input int idx);
        int v;
        case (idx)
            0:       v = 2;
            1:       v = 3;
            2:       v = 22;
            3:       v = -26;
            4:       v = 130;
            5:       v = -132;
            6:       v = 162;
            default: v = -168;
        endcase
        return D'(v);
    endfunction

    assign w_taken = branch_en_i & cond_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        w_enter_flush = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall_i) begin
                    if (halt_req_i) begin
                        state_d = S_HALT;
                    end else if (w_taken) begin
                        // Table read is the pre-write value when written this cycle.
                        pc_d          = pc_q + tbl_q[how_high_i];
                        state_d       = S_FLUSH;
                        w_enter_flush = 1'b1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!stall_i) state_d = S_RUN;
            end
            S_HALT: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) tbl_q[i] <= tbl_default(i);
        end else if (tbl_we_i) begin
            tbl_q[tbl_addr_i] <= tbl_data_i;
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == S_HALT && start_i) begin
            cnt_q <= '0;
        end else if (w_enter_flush && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign taken_cnt_o = cnt_q;
`endif

    assign prog_ctr_o    = pc_q;
    assign fetch_valid_o = (state_q == S_RUN);
    assign flush_o       = (state_q == S_FLUSH);
    assign done_o        = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_seq
// Purpose  : Directed self-checking bench for branch_seq (D = 12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_seq;

    localparam int D = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic         branch_en = 1'b0;
    logic         cond = 1'b0;
    logic [2:0]   how_high = '0;
    logic         halt_req = 1'b0;
    logic         tbl_we = 1'b0;
    logic [2:0]   tbl_addr = '0;
    logic [D-1:0] tbl_data = '0;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid;
    logic         flush;
    logic         done;
`ifdef BRANCH_COUNT_EN
    logic [15:0]  taken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_seq #(.D(D)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stall_i       (stall),
        .branch_en_i   (branch_en),
        .cond_i        (cond),
        .how_high_i    (how_high),
        .halt_req_i    (halt_req),
        .tbl_we_i      (tbl_we),
        .tbl_addr_i    (tbl_addr),
        .tbl_data_i    (tbl_data),
`ifdef BRANCH_COUNT_EN
        .taken_cnt_o   (taken_cnt),
`endif
        .prog_ctr_o    (prog_ctr),
        .fetch_valid_o (fetch_valid),
        .flush_o       (flush),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [D-1:0] pc, input logic fv,
                           input logic fl, input logic dn);
        chk({tag, ".pc"},    32'(prog_ctr),    32'(pc));
        chk({tag, ".fv"},    32'(fetch_valid), 32'(fv));
        chk({tag, ".flush"}, 32'(flush),       32'(fl));
        chk({tag, ".done"},  32'(done),        32'(dn));
    endtask

    task automatic reset_start();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_branch(input logic [2:0] hh);
        branch_en = 1'b1;
        cond      = 1'b1;
        how_high  = hh;
    endtask

    task automatic clr_branch();
        branch_en = 1'b0;
        cond      = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 12'h000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle_hold", 12'h000, 1'b0, 1'b0, 1'b0);

        // Sequential fetch after start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("run0", 12'h000, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_out($sformatf("seq%0d", i), D'(i), 1'b1, 1'b0, 1'b0);
        end

        // Stall in RUN holds pc; start ignored in RUN
        stall = 1'b1;
        start = 1'b1;
        tick();
        chk_out("stall_run", 12'h005, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        start = 1'b0;
        chk_out("start_in_run", 12'h006, 1'b1, 1'b0, 1'b0);

        // Negative branch from 4 with entry 3 (-26)
        reset_start();
        repeat (4) tick();
        chk("pre_br.pc", 32'(prog_ctr), 32'h004);
        set_branch(3'd3);
        tick();
        clr_branch();
        chk_out("br_neg", 12'hFEA, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("br_neg_run", 12'hFEA, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("br_neg_inc", 12'hFEB, 1'b1, 1'b0, 1'b0);

        // Upward wrap 0xFFF -> 0x000
        repeat (20) tick();
        chk("at_fff.pc", 32'(prog_ctr), 32'hFFF);
        tick();
        chk("wrap.pc", 32'(prog_ctr), 32'h000);

        // Entry 7 (-168) from 0x010
        repeat (16) tick();
        chk("at_010.pc", 32'(prog_ctr), 32'h010);
        set_branch(3'd7);
        tick();
        clr_branch();
        chk_out("br7", 12'hF68, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("br7_run", 12'hF68, 1'b1, 1'b0, 1'b0);

        // Concurrent table write and branch: old value used, new value afterwards
        reset_start();
        repeat (10) tick();
        chk("at_10.pc", 32'(prog_ctr), 32'd10);
        set_branch(3'd2);
        tbl_we   = 1'b1;
        tbl_addr = 3'd2;
        tbl_data = 12'd5;
        tick();
        clr_branch();
        tbl_we = 1'b0;
        chk_out("wr_br_old", 12'd32, 1'b0, 1'b1, 1'b0);
        tick();
        repeat (8) tick();
        chk("at_40.pc", 32'(prog_ctr), 32'd40);
        set_branch(3'd2);
        tick();
        clr_branch();
        chk_out("wr_br_new", 12'd45, 1'b0, 1'b1, 1'b0);
        tick();

        // Halt wins over taken branch; restart from HALT goes to 0
        reset_start();
        repeat (7) tick();
        set_branch(3'd0);
        halt_req = 1'b1;
        tick();
        clr_branch();
        halt_req = 1'b0;
        chk_out("halt", 12'd7, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("halt_hold", 12'd7, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("restart", 12'd0, 1'b1, 1'b0, 1'b0);
`ifdef BRANCH_COUNT_EN
        chk("cnt_cleared", 32'(taken_cnt), 32'd0);
`endif

        // Stall in FLUSH, then reset mid-FLUSH under stall
        set_branch(3'd0);
        tick();
        clr_branch();
        chk_out("fl_enter", 12'd2, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_COUNT_EN
        chk("cnt_one", 32'(taken_cnt), 32'd1);
`endif
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("fl_stall%0d", i), 12'd2, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk_out("rst_in_flush", 12'd0, 1'b0, 1'b0, 1'b0);
        rst   = 1'b0;
        stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
